// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL reset sequencer: state encoding and counter sizing.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        ST_HOLD      = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } seq_state_t;

    // Bits needed to hold the largest of the three cycle loads without wrapping.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level signal.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_reset_sequencer.sv
// Holds the PLL in reset, waits for a stable lock, then releases downstream reset;
// retries on lock timeout and parks in FAIL after MAX_RETRIES attempts.
//
// state     | meaning
// HOLD      | pll_rst asserted for RST_HOLD_CYCLES
// WAIT_LOCK | PLL released, waiting up to LOCK_TIMEOUT for lock
// STABLE    | lock seen, must persist LOCK_STABLE_CYCLES samples in total
// RUN       | downstream released, ready=1
// FAIL      | retries exhausted, waits for soft_reset or rst_n
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_HOLD_CYCLES    = 16,
    parameter int LOCK_TIMEOUT       = 65535,
    parameter int LOCK_STABLE_CYCLES = 256,
    parameter int MAX_RETRIES        = 3
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       soft_reset,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       sys_reset_n,
    output logic       ready,
    output logic       lock_fail,
    output logic [3:0] retry_count
);

    localparam int CW = cnt_width(RST_HOLD_CYCLES, LOCK_TIMEOUT, LOCK_STABLE_CYCLES);
    localparam logic [CW-1:0] HOLD_LOAD    = CW'(RST_HOLD_CYCLES);
    localparam logic [CW-1:0] TIMEOUT_LOAD = CW'(LOCK_TIMEOUT);
    // The WAIT_LOCK sample that triggers entry counts as the first stable cycle.
    localparam logic [CW-1:0] STABLE_LOAD  = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [3:0]    RETRY_MAX    = 4'(MAX_RETRIES);
    localparam logic [CW-1:0] CNT_ONE      = CW'(1);

    seq_state_t    state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [3:0]    retry_nxt;
    logic [3:0]    retry_inc;
    logic          locked_s;

    sync_2ff u_sync_lock (
        .clk   (refclk),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (locked_s)
    );

    assign retry_inc = (retry_count >= RETRY_MAX) ? retry_count : retry_count + 4'd1;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        retry_nxt = retry_count;
        if (soft_reset) begin
            state_nxt = ST_HOLD;
            cnt_nxt   = HOLD_LOAD;
            retry_nxt = 4'd0;
        end else begin
            case (state)
                ST_HOLD: begin
                    if (cnt <= CNT_ONE) begin
                        state_nxt = ST_WAIT_LOCK;
                        cnt_nxt   = TIMEOUT_LOAD;
                    end else begin
                        cnt_nxt = cnt - CNT_ONE;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (locked_s) begin
                        if (LOCK_STABLE_CYCLES <= 1) begin
                            state_nxt = ST_RUN;
                            retry_nxt = 4'd0;
                        end else begin
                            state_nxt = ST_STABLE;
                            cnt_nxt   = STABLE_LOAD;
                        end
                    end else if (cnt <= CNT_ONE) begin
                        retry_nxt = retry_inc;
                        cnt_nxt   = HOLD_LOAD;
                        state_nxt = (retry_inc == RETRY_MAX) ? ST_FAIL : ST_HOLD;
                    end else begin
                        cnt_nxt = cnt - CNT_ONE;
                    end
                end
                ST_STABLE: begin
                    if (!locked_s) begin
                        state_nxt = ST_WAIT_LOCK;
                        cnt_nxt   = TIMEOUT_LOAD;
                    end else if (cnt <= CNT_ONE) begin
                        state_nxt = ST_RUN;
                        retry_nxt = 4'd0;
                    end else begin
                        cnt_nxt = cnt - CNT_ONE;
                    end
                end
                ST_RUN: begin
                    if (!locked_s) begin
                        state_nxt = ST_HOLD;
                        cnt_nxt   = HOLD_LOAD;
                    end
                end
                ST_FAIL: begin
                    state_nxt = ST_FAIL;
                end
                default: begin
                    state_nxt = ST_HOLD;
                    cnt_nxt   = HOLD_LOAD;
                end
            endcase
        end
    end

    // Outputs decode next-state so they switch on the same edge as the state.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_HOLD;
            cnt         <= HOLD_LOAD;
            retry_count <= 4'd0;
            pll_rst     <= 1'b1;
            sys_reset_n <= 1'b0;
            ready       <= 1'b0;
            lock_fail   <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            retry_count <= retry_nxt;
            pll_rst     <= (state_nxt == ST_HOLD) || (state_nxt == ST_FAIL);
            sys_reset_n <= (state_nxt == ST_RUN);
            ready       <= (state_nxt == ST_RUN);
            lock_fail   <= (state_nxt == ST_FAIL);
        end
    end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer; edge numbers count refclk rises after rst_n release.
module tb_pll_reset_sequencer;

    logic       refclk = 1'b0;
    logic       rst_n = 1'b0;
    logic       soft_reset = 1'b0;
    logic       pll_locked = 1'b0;
    logic       pll_rst;
    logic       sys_reset_n;
    logic       ready;
    logic       lock_fail;
    logic [3:0] retry_count;

    int errors = 0;
    int checks = 0;

    pll_reset_sequencer #(
        .RST_HOLD_CYCLES    (4),
        .LOCK_TIMEOUT       (20),
        .LOCK_STABLE_CYCLES (8),
        .MAX_RETRIES        (2)
    ) dut (
        .refclk      (refclk),
        .rst_n       (rst_n),
        .soft_reset  (soft_reset),
        .pll_locked  (pll_locked),
        .pll_rst     (pll_rst),
        .sys_reset_n (sys_reset_n),
        .ready       (ready),
        .lock_fail   (lock_fail),
        .retry_count (retry_count)
    );

    always #5 refclk = ~refclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge refclk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge refclk);
        rst_n = 1'b0;
        repeat (2) @(negedge refclk);
        check("rst_pll_rst", 32'(pll_rst), 32'd1);
        check("rst_sys_reset_n", 32'(sys_reset_n), 32'd0);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_lock_fail", 32'(lock_fail), 32'd0);
        check("rst_retry", 32'(retry_count), 32'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        // Normal bring-up: lock asserted after edge 10, RUN at edge 20
        pll_locked = 1'b0;
        do_reset();
        tick(3);
        check("hold_e3_pll_rst", 32'(pll_rst), 32'd1);
        tick(1);
        check("hold_e4_pll_rst", 32'(pll_rst), 32'd0);
        tick(6);
        pll_locked = 1'b1;
        tick(9);
        check("norm_e19_ready", 32'(ready), 32'd0);
        check("norm_e19_sys", 32'(sys_reset_n), 32'd0);
        tick(1);
        check("norm_e20_ready", 32'(ready), 32'd1);
        check("norm_e20_sys", 32'(sys_reset_n), 32'd1);
        check("norm_e20_retry", 32'(retry_count), 32'd0);
        check("norm_e20_pll_rst", 32'(pll_rst), 32'd0);

        // Loss of lock in RUN: drop after edge 22, reset downstream at edge 25
        tick(2);
        pll_locked = 1'b0;
        tick(2);
        check("lol_e24_sys", 32'(sys_reset_n), 32'd1);
        tick(1);
        check("lol_e25_sys", 32'(sys_reset_n), 32'd0);
        check("lol_e25_ready", 32'(ready), 32'd0);
        check("lol_e25_pll_rst", 32'(pll_rst), 32'd1);
        tick(3);
        check("lol_e28_pll_rst", 32'(pll_rst), 32'd1);
        tick(1);
        check("lol_e29_pll_rst", 32'(pll_rst), 32'd0);

        // Lock glitch: high samples 11..15, low at 16, high from 17 -> RUN at 26
        pll_locked = 1'b0;
        do_reset();
        tick(10);
        pll_locked = 1'b1;
        tick(5);
        pll_locked = 1'b0;
        tick(1);
        pll_locked = 1'b1;
        tick(4);
        check("glitch_e20_ready", 32'(ready), 32'd0);
        tick(5);
        check("glitch_e25_ready", 32'(ready), 32'd0);
        tick(1);
        check("glitch_e26_ready", 32'(ready), 32'd1);
        check("glitch_e26_retry", 32'(retry_count), 32'd0);

        // No lock: first timeout at edge 24, FAIL at edge 48
        pll_locked = 1'b0;
        do_reset();
        tick(23);
        check("nolock_e23_retry", 32'(retry_count), 32'd0);
        check("nolock_e23_pll_rst", 32'(pll_rst), 32'd0);
        tick(1);
        check("nolock_e24_retry", 32'(retry_count), 32'd1);
        check("nolock_e24_pll_rst", 32'(pll_rst), 32'd1);
        check("nolock_e24_lock_fail", 32'(lock_fail), 32'd0);
        tick(23);
        check("nolock_e47_lock_fail", 32'(lock_fail), 32'd0);
        tick(1);
        check("nolock_e48_lock_fail", 32'(lock_fail), 32'd1);
        check("nolock_e48_retry", 32'(retry_count), 32'd2);
        check("nolock_e48_pll_rst", 32'(pll_rst), 32'd1);
        check("nolock_e48_sys", 32'(sys_reset_n), 32'd0);
        tick(50);
        check("fail_hold_lock_fail", 32'(lock_fail), 32'd1);
        check("fail_hold_pll_rst", 32'(pll_rst), 32'd1);
        check("fail_hold_ready", 32'(ready), 32'd0);

        // Recovery from FAIL via soft_reset at edge S; RUN at S+12
        pll_locked = 1'b1;
        tick(5);
        check("fail_locked_still_fail", 32'(lock_fail), 32'd1);
        soft_reset = 1'b1;
        tick(1);
        soft_reset = 1'b0;
        check("rec_lock_fail", 32'(lock_fail), 32'd0);
        check("rec_retry", 32'(retry_count), 32'd0);
        check("rec_pll_rst", 32'(pll_rst), 32'd1);
        tick(11);
        check("rec_s11_ready", 32'(ready), 32'd0);
        tick(1);
        check("rec_s12_ready", 32'(ready), 32'd1);
        check("rec_s12_sys", 32'(sys_reset_n), 32'd1);

        // Soft reset has priority in RUN even with lock present
        tick(3);
        soft_reset = 1'b1;
        tick(1);
        soft_reset = 1'b0;
        check("soft_run_ready", 32'(ready), 32'd0);
        check("soft_run_pll_rst", 32'(pll_rst), 32'd1);
        tick(12);
        check("soft_run_back_ready", 32'(ready), 32'd1);

        // Async reset in RUN takes effect between edges
        #3;
        rst_n = 1'b0;
        #1;
        check("async_sys", 32'(sys_reset_n), 32'd0);
        check("async_pll_rst", 32'(pll_rst), 32'd1);
        check("async_ready", 32'(ready), 32'd0);
        @(negedge refclk);
        rst_n = 1'b1;
        tick(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pll_reset_sequencer.md
PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 SHALL have parameter RST_HOLD_CYCLES, default 16: refclk cycles pll_rst is held high per attempt (min 1).
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 65535: max refclk cycles waited for lock per attempt (min 1).
REQ-003 SHALL have parameter LOCK_STABLE_CYCLES, default 256: consecutive synchronized-lock cycles required before release (min 1).
REQ-004 SHALL have parameter MAX_RETRIES, default 3: failed attempts before FAIL (1..15).
REQ-005 SHALL have port refclk  in  1  single clock; all logic in this domain.
REQ-006 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port soft_reset  in  1  synchronous one-cycle restart request.
REQ-008 SHALL have port pll_locked  in  1  PLL lock indication, asynchronous to refclk.
REQ-009 SHALL have port pll_rst  out  1  active-high reset to the PLL.
REQ-010 SHALL have port sys_reset_n  out  1  active-low reset to downstream logic.
REQ-011 SHALL have port ready  out  1  high only in RUN.
REQ-012 SHALL have port lock_fail  out  1  high only in FAIL.
REQ-013 SHALL have port retry_count  out  4  failed attempts since last RUN/restart, saturating at MAX_RETRIES.

Function
REQ-014 SHALL pass pll_locked through a 2-flop synchronizer (locked_s), giving 2-cycle input latency.
REQ-015 SHALL implement states HOLD, WAIT_LOCK, STABLE, RUN, FAIL with one shared down-counter.
REQ-016 HOLD: pll_rst=1; after RST_HOLD_CYCLES cycles -> WAIT_LOCK.
REQ-017 WAIT_LOCK: pll_rst=0; locked_s=1 -> STABLE; LOCK_TIMEOUT cycles without lock -> retry_count+1, then FAIL if new count == MAX_RETRIES, else HOLD.
REQ-018 STABLE: locked_s must stay 1 for LOCK_STABLE_CYCLES consecutive cycles -> RUN; any 0 -> WAIT_LOCK with timeout counter reloaded, retry_count unchanged.
REQ-019 RUN: sys_reset_n=1, ready=1, retry_count cleared on entry; locked_s=0 -> HOLD on next edge, sys_reset_n=0 on that same edge.
REQ-020 FAIL: pll_rst=1, sys_reset_n=0, lock_fail=1; exits only via soft_reset or rst_n.
REQ-021 soft_reset=1 in any state SHALL force HOLD next edge, clear retry_count, reload counter; it has priority over all other transitions in the same cycle.
REQ-022 All outputs SHALL be registered and decoded from next-state, so each output changes on the same edge as the state change.
REQ-023 sys_reset_n SHALL be 0 in every state except RUN; no glitch on state transitions.
REQ-024 Counter width SHALL be sized for the largest of the three cycle parameters; no wrap-around possible.

Reset
REQ-025 rst_n=0 SHALL asynchronously force state HOLD, pll_rst=1, sys_reset_n=0, ready=0, lock_fail=0, retry_count=0, synchronizer flops=0, counter=RST_HOLD_CYCLES.
REQ-026 rst_n asserted mid-sequence (any state, incl. RUN) SHALL abort immediately; sequence restarts from HOLD on first edge after release.

Structure
REQ-027 State enumeration and counter-width function SHALL live in shared package pll_seq_pkg.
REQ-028 The synchronizer SHALL be sub-module sync_2ff (1-bit, async active-low reset, reset value 0).

Verification (RST_HOLD_CYCLES=4, LOCK_TIMEOUT=20, LOCK_STABLE_CYCLES=8, MAX_RETRIES=2)
REQ-029 Normal: pll_locked rises 10 cycles after rst_n release and stays -> pll_rst falls at cycle 4, ready and sys_reset_n rise at cycle 10+2+8, retry_count=0.
REQ-030 Lock glitch: pll_locked high 5 cycles, low 1, high -> STABLE restarts; RUN reached 8 cycles after final synchronized rise, retry_count=0.
REQ-031 No lock: pll_locked held 0 -> retry_count 1 after first 20-cycle timeout, FAIL after second, lock_fail=1, pll_rst=1, sys_reset_n=0 held indefinitely.
REQ-032 Loss of lock in RUN: drop pll_locked -> 2 cycles later sys_reset_n=0, ready=0, pll_rst=1 for 4 cycles, then WAIT_LOCK.
REQ-033 Recovery: soft_reset pulse while in FAIL with pll_locked=1 -> lock_fail=0, retry_count=0 next edge, RUN after 4+8 cycles plus synchronizer latency.
REQ-034 Async reset in RUN: rst_n low mid-cycle -> sys_reset_n=0, pll_rst=1 without waiting for a refclk edge.
